fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   IF stage of the 5-stage RV32 pipeline. Producer of fetch_dec_reg = {instruction, pc}, the word decode consumes.
//   Owns the PC and runs a single-outstanding req/ready + rvalid handshake with instruction memory.
//   Honours the decode stall and applies branch/jump redirects from EX with a flush.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC of the first fetch after reset
//   NOP_INSTR  32'h0000_0013  bubble word (addi x0,x0,0) put in fetch_dec_reg on reset/flush
// PORTS
//   clk            in   1   clock, all state on posedge
//   rst            in   1   synchronous, active-high reset
//   stall          in   1   decode not accepting; fetch_dec_reg must hold
//   redirect_en    in   1   taken branch/jump from EX, flush and refetch
//   redirect_pc    in   32  target PC; bits [1:0] forced to 2'b00
//   imem_req       out  1   request valid
//   imem_addr      out  32  request address (word aligned)
//   imem_ready     in   1   request accepted this cycle when imem_req=1
//   imem_rvalid    in   1   read data valid (one response per accepted req, >=1 cycle later)
//   imem_rdata     in   32  instruction word
//   fetch_dec_reg  out  64  {instruction[63:32], pc[31:0]} registered to decode
//   fetch_valid    out  1   fetch_dec_reg holds a real instruction (0 = bubble)
// BEHAVIOUR
// - Reset (rst=1 at posedge)
//   - pc_q=RESET_PC, state=REQ, drop=0, hold buffer cleared.
//   - fetch_dec_reg={NOP_INSTR,32'h0}, fetch_valid=0.
//   - imem_req=0 while rst is high. First request (addr RESET_PC) goes out the cycle after rst falls.
//   - rst mid-transaction discards any outstanding response.
// - FSM states REQ, WAIT, HOLD
//   - REQ: imem_req=1, imem_addr=pc_q. Both stay stable until imem_ready. On imem_req&imem_ready go to WAIT.
//   - WAIT: imem_req=0. On imem_rvalid:
//     - drop=1: discard the data, clear drop, go to REQ.
//     - stall=0: fetch_dec_reg<={imem_rdata,pc_q}, fetch_valid<=1, pc_q<=pc_q+4, go to REQ.
//     - stall=1: capture {imem_rdata,pc_q} in the hold buffer, go to HOLD.
//   - HOLD: imem_req=0. When stall=0, load fetch_dec_reg from the buffer, fetch_valid<=1, pc_q<=pc_q+4, go to REQ.
//   - imem_rvalid outside WAIT is ignored.
// - Stall: fetch_dec_reg/fetch_valid hold their value on every cycle stall=1 with no redirect. A new fetch may be requested during stall.
// - Redirect: redirect has priority over stall and over everything except rst. On redirect_en at posedge:
//   - pc_q<={redirect_pc[31:2],2'b00}.
//   - fetch_dec_reg<={NOP_INSTR,32'h0}, fetch_valid<=0.
//   - Hold buffer discarded.
//   - If in WAIT with no rvalid this cycle, or in REQ with imem_ready=1 this cycle: drop<=1, next state WAIT. The stale response is discarded.
//   - Otherwise (REQ not accepted, HOLD, WAIT with rvalid) next state is REQ at the new PC.
// - Arithmetic: pc_q+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0. PC is always word aligned.
// - Timing: zero-wait memory (ready same cycle, rvalid next cycle) sees req in cycle N and output valid in cycle N+2. Peak throughput is 1 instruction per 2 cycles.
// TESTING
//   1. Reset release, ready=1, rvalid 1 cycle later, rdata=32'h00500093.
//      -> imem_addr 0,4,8 on successive requests.
//      -> fetch_dec_reg={32'h00500093,32'h0} two cycles after first req, fetch_valid=1.
//   2. stall=1 for 3 cycles while a response arrives.
//      -> fetch_dec_reg unchanged during stall; buffered word appears the cycle after stall drops.
//      -> no response lost, pc_q advances once.
//   3. redirect_en with redirect_pc=32'h0000_0103 while in WAIT; rvalid arrives next cycle.
//      -> that response is discarded, output={NOP_INSTR,0} with fetch_valid=0.
//      -> next imem_addr=32'h0000_0100.
//   4. redirect_en and stall both high in the same cycle.
//      -> flush wins: fetch_valid=0, next request goes to the target.
//   5. imem_ready low 4 cycles.
//      -> imem_req/imem_addr stable throughout; exactly one request accepted.
//   6. RESET_PC=32'hFFFF_FFFC.
//      -> second fetch address 32'h0000_0000.
//   7. rst asserted while in WAIT.
//      -> outputs return to reset values; late rvalid is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, fetches one instruction at a time from imem and registers {instr, pc} to decode.
// Latency: req accepted in cycle N, zero-wait memory answers in N+1, fetch_dec_reg valid in N+2 (1 instr / 2 cycles peak).
// Backpressure: decode stall freezes fetch_dec_reg; a response arriving under stall is parked in a one-entry hold buffer.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [63:0] fetch_dec_reg,
    output logic        fetch_valid
);

    // Word handed to decode; instr occupies the upper half.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fd_t;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam fd_t BUBBLE = '{instr: NOP_INSTR, pc: 32'h0000_0000};

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    fd_t         hold_q, hold_d;
    fd_t         out_q, out_d;
    logic        vld_q, vld_d;

    logic [31:0] pc_inc;
    logic [31:0] redirect_tgt;
    fd_t         resp_word;

    // PC increment wraps naturally at 2^32; redirect target is forced word aligned.
    assign pc_inc       = pc_q + 32'd4;
    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign resp_word    = '{instr: imem_rdata, pc: pc_q};

    // Request is held stable from REQ entry until the memory accepts it; silent while in reset.
    assign imem_req      = (state_q == REQ) && !rst;
    assign imem_addr     = pc_q;
    assign fetch_dec_reg = out_q;
    assign fetch_valid   = vld_q;

    // Next-state logic: redirect overrides stall and normal sequencing.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        hold_d  = hold_q;
        out_d   = out_q;
        vld_d   = vld_q;

        if (redirect_en) begin
            pc_d   = redirect_tgt;
            out_d  = BUBBLE;
            vld_d  = 1'b0;
            hold_d = '0;
            // A request is (or is about to be) in flight with its response still to come:
            // wait for it and throw it away before fetching the target.
            if (((state_q == WAIT) && !imem_rvalid) || ((state_q == REQ) && imem_ready)) begin
                drop_d  = 1'b1;
                state_d = WAIT;
            end else begin
                drop_d  = 1'b0;
                state_d = REQ;
            end
        end else begin
            case (state_q)
                REQ: begin
                    if (imem_ready) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = REQ;
                        end else if (!stall) begin
                            out_d   = resp_word;
                            vld_d   = 1'b1;
                            pc_d    = pc_inc;
                            state_d = REQ;
                        end else begin
                            hold_d  = resp_word;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        out_d   = hold_q;
                        vld_d   = 1'b1;
                        pc_d    = pc_inc;
                        state_d = REQ;
                    end
                end
                default: begin
                    state_d = REQ;
                end
            endcase
        end
    end

    // State register with synchronous reset; reset also forgets any outstanding response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            hold_q  <= '0;
            out_q   <= BUBBLE;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            hold_q  <= hold_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: two instances (default RESET_PC and RESET_PC at the top of memory).
// Memory model returns addr ^ MAGIC with a selectable 1- or 2-cycle response latency.
// Stimulus is a linear cycle-by-cycle script; outputs are sampled 1 time unit after each posedge.
module tb_fetch_stage;

    localparam logic [31:0] MAGIC = 32'h0050_0093;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic        a_req;
    logic [31:0] a_addr;
    logic        a_ready = 1'b1;
    logic        a_rvalid = 1'b0;
    logic [31:0] a_rdata = 32'h0;
    logic [63:0] a_fdr;
    logic        a_fv;

    logic        b_req;
    logic [31:0] b_addr;
    logic        b_ready = 1'b1;
    logic        b_rvalid = 1'b0;
    logic [31:0] b_rdata = 32'h0;
    logic [63:0] b_fdr;
    logic        b_fv;

    int          lat = 1;
    int          acc_cnt = 0;
    logic        a_pend = 1'b0;
    logic [31:0] a_paddr = 32'h0;

    int          errors = 0;
    int          checks = 0;
    int          acc_before = 0;

    fetch_stage u_a (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .imem_req(a_req), .imem_addr(a_addr), .imem_ready(a_ready),
        .imem_rvalid(a_rvalid), .imem_rdata(a_rdata),
        .fetch_dec_reg(a_fdr), .fetch_valid(a_fv)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_b (
        .clk(clk), .rst(rst), .stall(1'b0),
        .redirect_en(1'b0), .redirect_pc(32'h0),
        .imem_req(b_req), .imem_addr(b_addr), .imem_ready(b_ready),
        .imem_rvalid(b_rvalid), .imem_rdata(b_rdata),
        .fetch_dec_reg(b_fdr), .fetch_valid(b_fv)
    );

    always #5 clk = ~clk;

    // Memory for instance A: one outstanding request, latency 1 or 2 cycles.
    always @(posedge clk) begin
        a_rvalid <= 1'b0;
        if (a_pend) begin
            a_rvalid <= 1'b1;
            a_rdata  <= a_paddr ^ MAGIC;
            a_pend   <= 1'b0;
        end
        if (a_req && a_ready) begin
            acc_cnt <= acc_cnt + 1;
            if (lat == 1) begin
                a_rvalid <= 1'b1;
                a_rdata  <= a_addr ^ MAGIC;
            end else begin
                a_pend  <= 1'b1;
                a_paddr <= a_addr;
            end
        end
    end

    // Memory for instance B: zero-wait.
    always @(posedge clk) begin
        b_rvalid <= b_req && b_ready;
        if (b_req && b_ready) begin
            b_rdata <= b_addr ^ MAGIC;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // ---- reset state
        tick();
        tick();
        chk("rst_req",   {63'h0, a_req}, 64'h0);
        chk("rst_valid", {63'h0, a_fv},  64'h0);
        chk("rst_fdr",   a_fdr, {NOP, 32'h0});
        chk("rst_b_req", {63'h0, b_req}, 64'h0);

        // ---- 1: basic fetch, zero-wait memory
        rst = 1'b0;
        #1;
        chk("t1_req0",  {63'h0, a_req}, 64'h1);
        chk("t1_addr0", {32'h0, a_addr}, 64'h0);
        chk("t6_b_addr0", {32'h0, b_addr}, {32'h0, 32'hFFFF_FFFC});
        tick();                                   // cycle 1: WAIT
        chk("t1_req_wait", {63'h0, a_req}, 64'h0);
        chk("t1_valid_wait", {63'h0, a_fv}, 64'h0);
        tick();                                   // cycle 2: first output
        chk("t1_fdr0",   a_fdr, {32'h0050_0093, 32'h0});
        chk("t1_valid0", {63'h0, a_fv}, 64'h1);
        chk("t1_addr1",  {32'h0, a_addr}, {32'h0, 32'h4});
        chk("t1_req1",   {63'h0, a_req}, 64'h1);
        chk("t6_b_addr1", {32'h0, b_addr}, 64'h0);
        chk("t6_b_fdr0",  b_fdr, {32'hFFAF_FF6F, 32'hFFFF_FFFC});
        tick();                                   // cycle 3
        tick();                                   // cycle 4
        chk("t1_fdr1",  a_fdr, {32'h0050_0097, 32'h4});
        chk("t1_addr2", {32'h0, a_addr}, {32'h0, 32'h8});

        // ---- 2: stall for 3 cycles while the response for addr 8 arrives
        stall = 1'b1;
        tick();                                   // cycle 5: WAIT, rvalid present
        chk("t2_hold_a", a_fdr, {32'h0050_0097, 32'h4});
        tick();                                   // cycle 6: HOLD
        chk("t2_hold_b", a_fdr, {32'h0050_0097, 32'h4});
        chk("t2_req_hold", {63'h0, a_req}, 64'h0);
        tick();                                   // cycle 7
        chk("t2_hold_c", a_fdr, {32'h0050_0097, 32'h4});
        chk("t2_valid_hold", {63'h0, a_fv}, 64'h1);
        stall = 1'b0;
        tick();                                   // cycle 8
        chk("t2_buffered", a_fdr, {32'h0050_009B, 32'h8});
        chk("t2_addr_next", {32'h0, a_addr}, {32'h0, 32'hC});

        // ---- 3: redirect in WAIT before the (2-cycle) response
        lat = 2;
        tick();                                   // cycle 9: WAIT, no rvalid yet
        chk("t3_no_rvalid", {63'h0, a_rvalid}, 64'h0);
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();                                   // cycle 10: stale rvalid arrives
        redirect_en = 1'b0;
        chk("t3_fdr_flush",   a_fdr, {NOP, 32'h0});
        chk("t3_valid_flush", {63'h0, a_fv}, 64'h0);
        chk("t3_req_drop",    {63'h0, a_req}, 64'h0);
        tick();                                   // cycle 11
        chk("t3_fdr_after",   a_fdr, {NOP, 32'h0});
        chk("t3_valid_after", {63'h0, a_fv}, 64'h0);
        chk("t3_req_tgt",     {63'h0, a_req}, 64'h1);
        chk("t3_addr_tgt",    {32'h0, a_addr}, {32'h0, 32'h100});
        lat = 1;

        // ---- 4: redirect and stall together
        tick();                                   // cycle 12
        tick();                                   // cycle 13
        chk("t4_fdr_pre",   a_fdr, {32'h0050_0193, 32'h100});
        chk("t4_valid_pre", {63'h0, a_fv}, 64'h1);
        stall       = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();                                   // cycle 14
        redirect_en = 1'b0;
        chk("t4_valid_flush", {63'h0, a_fv}, 64'h0);
        chk("t4_fdr_flush",   a_fdr, {NOP, 32'h0});
        tick();                                   // cycle 15
        chk("t4_req_tgt",  {63'h0, a_req}, 64'h1);
        chk("t4_addr_tgt", {32'h0, a_addr}, {32'h0, 32'h200});
        chk("t4_valid_15", {63'h0, a_fv}, 64'h0);
        stall = 1'b0;

        // ---- 5: imem_ready low for 4 cycles
        a_ready    = 1'b0;
        acc_before = acc_cnt;
        for (int i = 0; i < 4; i++) begin
            tick();                               // cycles 16..19
            chk("t5_req_stable",  {63'h0, a_req}, 64'h1);
            chk("t5_addr_stable", {32'h0, a_addr}, {32'h0, 32'h200});
        end
        a_ready = 1'b1;
        tick();                                   // cycle 20: WAIT
        chk("t5_one_accept", 64'(acc_cnt - acc_before), 64'h1);
        chk("t5_req_wait",   {63'h0, a_req}, 64'h0);
        tick();                                   // cycle 21
        chk("t5_fdr", a_fdr, {32'h0050_0293, 32'h200});
        chk("t5_addr_next", {32'h0, a_addr}, {32'h0, 32'h204});

        // ---- 7: reset while in WAIT, response arrives late
        lat = 2;
        tick();                                   // cycle 22: WAIT
        rst = 1'b1;
        tick();                                   // cycle 23: in reset, late rvalid present
        chk("t7_valid_rst", {63'h0, a_fv}, 64'h0);
        chk("t7_fdr_rst",   a_fdr, {NOP, 32'h0});
        chk("t7_req_rst",   {63'h0, a_req}, 64'h0);
        lat = 1;
        rst = 1'b0;
        #1;
        chk("t7_req_restart",  {63'h0, a_req}, 64'h1);
        chk("t7_addr_restart", {32'h0, a_addr}, 64'h0);
        tick();                                   // cycle 24: WAIT
        chk("t7_valid_ignored", {63'h0, a_fv}, 64'h0);
        chk("t7_fdr_ignored",   a_fdr, {NOP, 32'h0});
        tick();                                   // cycle 25
        chk("t7_fdr_restart",   a_fdr, {32'h0050_0093, 32'h0});
        chk("t7_valid_restart", {63'h0, a_fv}, 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
